conv_encoder_byte: RTL
======================

CONV_ENCODER_BYTE -- requirements
Module: conv_encoder_byte

Interface
REQ-001 SHALL have parameter K, default 7: constraint length; M = K-1 memory bits.
REQ-002 SHALL have parameter G0, default 7'b1111001 (171 octal): generator for symbol bit 1.
REQ-003 SHALL have parameter G1, default 7'b1011011 (133 octal): generator for symbol bit 0.
REQ-004 SHALL have parameter MAX_FRAME, default 32: maximum symbols emitted per frame.
REQ-005 SHALL have ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input byte offered.
- in_data  in  8  data bits, LSB transmitted first.
- in_nbits  in  4  valid bits in in_data (1..8); 0 treated as 8.
- in_last  in  1  byte is the last of the frame.
- tail_en  in  1  append M zero tail bits; sampled on the first byte of a frame.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- out_valid  out  1  out_data holds a packed symbol byte.
- out_data  out  8  symbol k of the byte at bits [2k+1:2k], k=0..3.
- out_nsym  out  3  valid symbols in out_data (1..4).
- out_last  out  1  final byte of frame.
- out_ready  in  1  byte consumed when out_valid && out_ready.
- busy  out  1  high outside IDLE.
- overflow  out  1  sticky: frame exceeded MAX_FRAME symbols.
- frame_done  out  1  one-cycle pulse at frame end.

Function
REQ-006 SHALL implement states IDLE, ENCODE, TAIL, FLUSH, DONE.
REQ-007 Encoder shift register sr (M bits) SHALL be 0 on entry to each frame.
REQ-008 Per encoded bit b: v = {sr, b}; symbol[1] = ^(v & G0); symbol[0] = ^(v & G1); sr <= {sr[M-2:0], b}.
REQ-009 in_ready SHALL be 1 only in IDLE or ENCODE when no held bits remain and in_last not yet accepted in this frame.
REQ-010 IDLE: byte accept latches in_data/in_nbits/in_last, samples tail_en, clears overflow, goes to ENCODE.
REQ-011 ENCODE SHALL encode at most one bit per cycle, LSB first, starting the cycle after accept.
REQ-012 Symbols SHALL pack into an assembly register slot 0..3 in order; the edge writing slot 3 SHALL load the full byte into out_data (out_nsym=4) and set out_valid, provided out_valid==0 or out_ready==1 that cycle; otherwise the bit SHALL stall (sr and counters unchanged).
REQ-013 Output load and consumer handshake in the same cycle SHALL be allowed without a bubble.
REQ-014 out_data, out_nsym, out_last SHALL remain stable while out_valid && !out_ready.
REQ-015 After last bit of the in_last byte: go to TAIL if tail_en sampled 1, else FLUSH.
REQ-016 TAIL SHALL encode exactly M zero bits under the same stall rules, then go to FLUSH.
REQ-017 FLUSH: if 1..3 symbols pending, load them into out_data zero-padded, out_nsym=count, under the REQ-012 slot rule; then DONE.
REQ-018 out_last SHALL be 1 on the byte containing the frame's final symbol (full or partial), 0 otherwise.
REQ-019 A symbol counter SHALL cap emissions at MAX_FRAME; data or tail bits beyond cap SHALL be consumed without emission and set overflow.
REQ-020 DONE: after the out_last byte is consumed, pulse frame_done for one cycle and return to IDLE.
REQ-021 Counters SHALL be wide enough for MAX_FRAME without wrap; in_data ignored when not accepted.

Reset
REQ-022 rst SHALL force IDLE, sr=0, counters and assembly register 0, held byte cleared.
REQ-023 Reset outputs: in_ready=1, out_valid=0, out_data=0, out_nsym=0, out_last=0, busy=0, overflow=0, frame_done=0.
REQ-024 rst mid-frame SHALL discard all pending bits and symbols with no further output.

Verification
REQ-025 Impulse: byte 0x01, nbits=1, last, tail_en=1, out_ready=1 -> 0xC7 (nsym 4, last 0), then 0x3B (nsym 3, last 1), frame_done pulse.
REQ-026 Zeros: 0x00, nbits=8, last, tail_en=0 -> 0x00 nsym 4, then 0x00 nsym 4 last 1; first out_valid 4 cycles after accept edge.
REQ-027 Backpressure: impulse case with out_ready=0 for 10 cycles -> out_data holds 0xC7, out_valid stays 1, no further in_ready; release yields 0x3B correctly.
REQ-028 Overflow: five 0xFF bytes, nbits=8, tail_en=0 -> exactly 8 output bytes, last on 8th, overflow=1 until next frame accept.
REQ-029 Reset mid-frame: rst after 2 output bytes -> outputs at reset values next cycle; subsequent impulse frame reproduces REQ-025.

Source files
------------

// File: rtl/conv_encoder_byte.sv
// conv_encoder_byte
//   Rate-1/2 convolutional encoder working on a byte stream. Input bytes
//   carry 1..8 data bits (LSB first); each encoded bit yields a 2-bit symbol,
//   and four symbols are packed per output byte (symbol k at bits [2k+1:2k]).
//   A frame optionally ends with M zero tail bits. Emission is capped at
//   MAX_FRAME symbols per frame; excess bits are consumed silently and
//   raise the sticky overflow flag.
//
// Handshakes (both sides): a byte transfers on a rising clk edge where
//   valid && ready are both high. The producer holds data stable while valid
//   is high and ready is low; ready may depend on state but never on valid.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   in_valid/in_ready, in_data, in_nbits, in_last, tail_en : input byte stream
//   out_valid/out_ready, out_data, out_nsym, out_last      : symbol byte stream
//   busy            high whenever not IDLE
//   overflow        sticky: frame exceeded MAX_FRAME symbols
//   frame_done      one-cycle pulse after the final byte is consumed
//   dbg_state       current FSM state encoding
module conv_encoder_byte #(
  parameter int             K         = 7,
  parameter logic [K-1:0]   G0        = 7'b1111001,
  parameter logic [K-1:0]   G1        = 7'b1011011,
  parameter int             MAX_FRAME = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic [3:0] in_nbits,
  input  logic       in_last,
  input  logic       tail_en,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic [2:0] out_nsym,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy,
  output logic       overflow,
  output logic       frame_done,
  output logic [2:0] dbg_state
);

  localparam int M  = K - 1;
  localparam int CW = $clog2(MAX_FRAME + 1);
  localparam int TW = $clog2(K);
  localparam logic [CW-1:0] CNT_CAP  = CW'(MAX_FRAME);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_FRAME - 1);
  localparam logic [TW-1:0] TAIL_END = TW'(M - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ENCODE = 3'd1,
    S_TAIL   = 3'd2,
    S_FLUSH  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t r_state, w_next;

  logic [M-1:0]  r_sr;
  logic [7:0]    r_data;
  logic [3:0]    r_bits_left;
  logic          r_last;
  logic          r_tail_en;
  logic [TW-1:0] r_tail_cnt;
  logic [CW-1:0] r_sym_cnt;
  logic [1:0]    r_slot;
  logic [7:0]    r_asm;
  logic          r_out_valid;
  logic [7:0]    r_out_data;
  logic [2:0]    r_out_nsym;
  logic          r_out_last;
  logic          r_overflow;
  logic          r_frame_done;

  logic          w_accept;
  logic          w_bit_avail;
  logic          w_b;
  logic [K-1:0]  w_v;
  logic [1:0]    w_sym;
  logic          w_capped;
  logic          w_out_free;
  logic          w_full_load;
  logic          w_step;
  logic          w_flush_load;
  logic          w_final;

  // Bit/symbol datapath decode
  always_comb begin
    in_ready     = (r_state == S_IDLE) ||
                   (r_state == S_ENCODE && r_bits_left == 4'd0 && !r_last);
    w_accept     = in_valid && in_ready;
    w_bit_avail  = (r_state == S_ENCODE && r_bits_left != 4'd0) || (r_state == S_TAIL);
    w_b          = (r_state == S_TAIL) ? 1'b0 : r_data[0];
    w_v          = {r_sr, w_b};
    w_sym        = {^(w_v & G0), ^(w_v & G1)};
    w_capped     = (r_sym_cnt == CNT_CAP);
    // The output register can take a new byte if empty or being drained now.
    w_out_free   = !r_out_valid || out_ready;
    w_full_load  = w_bit_avail && !w_capped && (r_slot == 2'd3);
    // A bit completing a byte stalls until the output register can take it.
    w_step       = w_bit_avail && (!w_full_load || w_out_free);
    w_flush_load = (r_state == S_FLUSH) && (r_slot != 2'd0) && w_out_free;
    // This symbol is the frame's last emitted one: end of data without tail,
    // end of tail, or the symbol that reaches the cap.
    w_final      = (r_state == S_ENCODE && r_bits_left == 4'd1 && r_last && !r_tail_en) ||
                   (r_state == S_TAIL && r_tail_cnt == TAIL_END) ||
                   (r_sym_cnt == CNT_LAST);
  end

  // FSM next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_ENCODE;
      S_ENCODE: if (w_step && r_bits_left == 4'd1 && r_last)
                  w_next = r_tail_en ? S_TAIL : S_FLUSH;
      S_TAIL:   if (w_step && r_tail_cnt == TAIL_END) w_next = S_FLUSH;
      S_FLUSH:  if (r_slot == 2'd0 || w_out_free) w_next = S_DONE;
      S_DONE:   if (w_out_free) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr         <= '0;
      r_data       <= '0;
      r_bits_left  <= '0;
      r_last       <= 1'b0;
      r_tail_en    <= 1'b0;
      r_tail_cnt   <= '0;
      r_sym_cnt    <= '0;
      r_slot       <= '0;
      r_asm        <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_nsym   <= '0;
      r_out_last   <= 1'b0;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      // DONE leaves once the out_last byte has gone (or is going) out.
      r_frame_done <= (r_state == S_DONE) && w_out_free;

      if (r_out_valid && out_ready) r_out_valid <= 1'b0;

      if (w_accept) begin
        r_data      <= in_data;
        // 0 (and any out-of-range count) means a full byte.
        r_bits_left <= (in_nbits == 4'd0 || in_nbits > 4'd8) ? 4'd8 : in_nbits;
        r_last      <= in_last;
        if (r_state == S_IDLE) begin
          r_tail_en  <= tail_en;
          r_overflow <= 1'b0;
          r_sr       <= '0;
          r_sym_cnt  <= '0;
          r_slot     <= '0;
          r_asm      <= '0;
          r_tail_cnt <= '0;
        end
      end

      if (w_step) begin
        r_sr <= {r_sr[M-2:0], w_b};
        if (r_state == S_ENCODE) begin
          r_data      <= {1'b0, r_data[7:1]};
          r_bits_left <= r_bits_left - 4'd1;
        end else begin
          r_tail_cnt  <= r_tail_cnt + TW'(1);
        end
        if (w_capped) begin
          r_overflow <= 1'b1;
        end else begin
          r_sym_cnt <= r_sym_cnt + CW'(1);
          if (r_slot == 2'd3) begin
            r_out_data  <= {w_sym, r_asm[5:0]};
            r_out_nsym  <= 3'd4;
            r_out_last  <= w_final;
            r_out_valid <= 1'b1;
            r_slot      <= 2'd0;
            r_asm       <= '0;
          end else begin
            r_asm[{r_slot, 1'b0} +: 2] <= w_sym;
            r_slot <= r_slot + 2'd1;
          end
        end
      end

      // Unused high slots of r_asm are already zero, giving the padding.
      if (w_flush_load) begin
        r_out_data  <= r_asm;
        r_out_nsym  <= {1'b0, r_slot};
        r_out_last  <= 1'b1;
        r_out_valid <= 1'b1;
        r_slot      <= 2'd0;
        r_asm       <= '0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_nsym   = r_out_nsym;
  assign out_last   = r_out_last;
  assign busy       = (r_state != S_IDLE);
  assign overflow   = r_overflow;
  assign frame_done = r_frame_done;
  assign dbg_state  = r_state;

endmodule
